std_sync_queue: RTL and testbench
=================================

Name: std_sync_queue

Overview:
- Parametrised successor to the Calyx two-port M-structure synchronisation register.
- Generalises it to a DEPTH-entry blocking FIFO with WRITERS write ports and READERS read ports, each side arbitrated round-robin.
- Writes block while the queue is full; reads block while it is empty.
- Used by Calyx `par` arms that exchange values through a shared synchronised cell; with WRITERS=2, READERS=2, DEPTH=1 it is cycle-equivalent to the two-port M-structure register.

Parameters:
- WIDTH, 32, data width of each entry.
- DEPTH, 1, number of entries; legal range 1..256.
- WRITERS, 2, number of write ports; legal range 1..8.
- READERS, 2, number of read ports; legal range 1..8.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WRITERS*WIDTH  write data; port i occupies bits [i*WIDTH +: WIDTH].
- write_en  input  WRITERS  per-port write request.
- read_en  input  READERS  per-port read request.
- out  output  READERS*WIDTH  read data; port j occupies bits [j*WIDTH +: WIDTH].
- write_done  output  WRITERS  one-cycle pulse: write of port i committed.
- read_done  output  READERS  one-cycle pulse: read of port j committed; out slice j valid in the same cycle.
- peek  output  WIDTH  most recently written value.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (synchronous, active-high, clk rising edge) clears:
  - count, head and tail pointers, both arbiter pointers.
  - write_done, read_done, out, peek: all 0.
  - Storage contents are don't-care.
- Reset mid-operation: in-flight requests are dropped, with no done pulse and no data retained. A requester holding its enable high is served normally from the first cycle after reset deasserts.
- Requester contract:
  - write_en[i] and in slice i stay stable until write_done[i].
  - read_en[j] stays high until read_done[j] and drops in the cycle after it.
- Write commit:
  - Occurs when count < DEPTH at the start of the cycle and at least one write_en is high.
  - Exactly one writer is granted; in[g] is stored at tail, tail advances with wrap from DEPTH-1 to 0, and peek <= in[g].
  - write_done[g] = 1 on the next cycle; all other write_done bits are 0.
- Read commit:
  - Occurs when count > 0 at the start of the cycle and at least one read_en is high.
  - Exactly one reader is granted; out slice g <= entry at head, head advances with wrap.
  - read_done[g] = 1 on the next cycle. Latency is 1 cycle from request to done.
- Out slices that are not being committed are driven to 'x each cycle, i.e. data is valid only alongside read_done.
- Simultaneous read and write commits in one cycle are allowed; count is unchanged.
  - No bypass: a write into an empty queue cannot be read in the same cycle.
  - A read from a full queue does not free a slot for a same-cycle write.
- DEPTH=1: the queue alternates strictly between full and empty, exactly like the M-structure register.
- Arbitration (independent per side):
  - Pointer p, reset to 0. Grant goes to the first requester at index >= p, scanning upward with wrap.
  - If two or more requesters were active and a grant was issued, p <= (g+1) mod N.
  - With a single requester, or no commit, p holds.
- count is registered and equals the number of committed writes minus committed reads; it never exceeds DEPTH and never goes below 0.
- Requests while blocked (full or empty) wait indefinitely; no done pulse is issued.
- Width rules:
  - Pointers are $clog2(DEPTH) bits, minimum 1.
  - Arbiter pointers are $clog2(N) bits, minimum 1.
- Verilator-only self checks ($error on):
  - More than one write_done bit or more than one read_done bit set.
  - count > DEPTH.

Optional Feature:
- Macro: STD_SYNC_QUEUE_HOLD_OUT_EN.
- Defined:
  - Each out slice holds the value of its last committed read (0 after reset) instead of going to 'x.
  - Storage slots are not scrubbed on read.
- Undefined:
  - Uncommitted out slices are driven 'x every cycle.
  - A slot read from becomes 'x, for simulation visibility of stale-data use.

Test Plan:
- Reset then hold write_en=01, in[0]=0xAA (DEPTH=1): write_done=01 one cycle later, count=1, peek=0xAA. A second write stays blocked with write_done=00 until a read commits.
- DEPTH=1, full with 0xAA, read_en=11 three times with refills of 0x01, 0x02: read_done sequence 01, 10, 01 (round-robin), out slice data 0xAA, 0x01, 0x02.
- DEPTH=4, WRITERS=3, write_en=111 for 4 cycles: grants to ports 0,1,2,0, count 1→4. The remaining request blocks while count stays 4.
- DEPTH=4, count=2, write 0x55 and read in the same cycle: count stays 2. The read returns the oldest entry (FIFO order), and head and tail wrap correctly after 5 operations.
- Empty queue, read_en=01 held: no read_done for 10 cycles. A write of 0x33 commits, then read_done[0] pulses the following cycle with out[0]=0x33.
- Assert reset while count=3 with requests pending: next cycle count=0, peek=0, all done bits 0. After release, a pending write_en commits on the first cycle.

Source files
------------

// File: rtl/std_sync_queue.sv
// Blocking FIFO with round-robin arbitrated write and read ports; successor to the
// two-port M-structure register. Define STD_SYNC_QUEUE_HOLD_OUT_EN to hold out slices between reads.
module std_sync_queue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1,
  parameter int WRITERS = 2,
  parameter int READERS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WRITERS*WIDTH-1:0]   in,
  input  logic [WRITERS-1:0]         write_en,
  input  logic [READERS-1:0]         read_en,
  output logic [READERS*WIDTH-1:0]   out,
  output logic [WRITERS-1:0]         write_done,
  output logic [READERS-1:0]         read_done,
  output logic [WIDTH-1:0]           peek,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WAW = (WRITERS > 1) ? $clog2(WRITERS) : 1;
  localparam int RAW = (READERS > 1) ? $clog2(READERS) : 1;

  logic [WIDTH-1:0]         mem_q [DEPTH];
  logic [CW-1:0]            count_q;
  logic [PW-1:0]            head_q, tail_q;
  logic [WAW-1:0]           wptr_q;
  logic [RAW-1:0]           rptr_q;
  logic [WRITERS-1:0]       write_done_q;
  logic [READERS-1:0]       read_done_q;
  logic [READERS*WIDTH-1:0] out_q;
  logic [WIDTH-1:0]         peek_q;

  logic                     w_commit, r_commit, w_multi, r_multi;
  logic [2*WRITERS-1:0]     w_rot_full;
  logic [2*READERS-1:0]     r_rot_full;
  logic [WAW-1:0]           w_off, w_gnt;
  logic [RAW-1:0]           r_off, r_gnt;
  logic [WAW:0]             w_sum;
  logic [RAW:0]             r_sum;

  // Occupancy is sampled at the start of the cycle, so there is no bypass either way.
  assign w_commit = (count_q < CW'(DEPTH)) && (|write_en);
  assign r_commit = (count_q != '0) && (|read_en);
  assign w_multi  = |(write_en & (write_en - WRITERS'(1)));
  assign r_multi  = |(read_en & (read_en - READERS'(1)));

  // Rotate requests so index 0 is the pointer, take the lowest set bit, rotate back.
  always_comb begin
    w_rot_full = {write_en, write_en} >> wptr_q;
    w_off      = '0;
    for (int k = WRITERS - 1; k >= 0; k--) begin
      if (w_rot_full[k]) w_off = WAW'(k);
    end
    w_sum = {1'b0, wptr_q} + {1'b0, w_off};
    if (w_sum >= (WAW+1)'(WRITERS)) w_sum = w_sum - (WAW+1)'(WRITERS);
    w_gnt = w_sum[WAW-1:0];
  end

  always_comb begin
    r_rot_full = {read_en, read_en} >> rptr_q;
    r_off      = '0;
    for (int k = READERS - 1; k >= 0; k--) begin
      if (r_rot_full[k]) r_off = RAW'(k);
    end
    r_sum = {1'b0, rptr_q} + {1'b0, r_off};
    if (r_sum >= (RAW+1)'(READERS)) r_sum = r_sum - (RAW+1)'(READERS);
    r_gnt = r_sum[RAW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      write_done_q <= '0;
      read_done_q  <= '0;
      out_q        <= '0;
      peek_q       <= '0;
    end else begin
      write_done_q <= '0;
      read_done_q  <= '0;
`ifndef STD_SYNC_QUEUE_HOLD_OUT_EN
      out_q        <= 'x;
`endif
      if (w_commit) begin
        tail_q               <= (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
        peek_q               <= in[w_gnt*WIDTH +: WIDTH];
        write_done_q[w_gnt]  <= 1'b1;
        if (w_multi) wptr_q  <= (w_gnt == WAW'(WRITERS - 1)) ? '0 : w_gnt + WAW'(1);
      end
      if (r_commit) begin
        out_q[r_gnt*WIDTH +: WIDTH] <= mem_q[head_q];
        head_q                      <= (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
        read_done_q[r_gnt]          <= 1'b1;
        if (r_multi) rptr_q         <= (r_gnt == RAW'(READERS - 1)) ? '0 : r_gnt + RAW'(1);
      end
      unique case ({w_commit, r_commit})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head and tail never alias on a cycle with both commits, so write and scrub cannot collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_commit) mem_q[tail_q] <= in[w_gnt*WIDTH +: WIDTH];
`ifndef STD_SYNC_QUEUE_HOLD_OUT_EN
      if (r_commit) mem_q[head_q] <= 'x;
`endif
    end
  end

  assign out        = out_q;
  assign write_done = write_done_q;
  assign read_done  = read_done_q;
  assign peek       = peek_q;
  assign count      = count_q;

  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(write_done_q)) else $error("std_sync_queue: multiple write_done bits");
      assert ($onehot0(read_done_q)) else $error("std_sync_queue: multiple read_done bits");
      assert (count_q <= CW'(DEPTH)) else $error("std_sync_queue: count above DEPTH");
    end
  end
endmodule

// File: tb/tb_std_sync_queue.sv
// Directed bench for std_sync_queue: a DEPTH=1 two-port instance and a DEPTH=4 three-writer instance.
module tb_std_sync_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: M-structure configuration
  logic        rst_a;
  logic [15:0] in_a, out_a;
  logic [1:0]  we_a, re_a, wd_a, rd_a;
  logic [7:0]  peek_a;
  logic [0:0]  cnt_a;

  // Instance B: DEPTH=4, three writers
  logic        rst_b;
  logic [23:0] in_b;
  logic [15:0] out_b;
  logic [2:0]  we_b, wd_b;
  logic [1:0]  re_b, rd_b;
  logic [7:0]  peek_b;
  logic [2:0]  cnt_b;

  std_sync_queue #(.WIDTH(8), .DEPTH(1), .WRITERS(2), .READERS(2)) dut_a (
    .clk(clk), .reset(rst_a), .in(in_a), .write_en(we_a), .read_en(re_a),
    .out(out_a), .write_done(wd_a), .read_done(rd_a), .peek(peek_a), .count(cnt_a));

  std_sync_queue #(.WIDTH(8), .DEPTH(4), .WRITERS(3), .READERS(2)) dut_b (
    .clk(clk), .reset(rst_b), .in(in_b), .write_en(we_b), .read_en(re_b),
    .out(out_b), .write_done(wd_b), .read_done(rd_b), .peek(peek_b), .count(cnt_b));

  // Scoreboard: write entries are expected done masks, read entries are {port, data}
  logic [7:0]  exp_wr_a[$], exp_wr_b[$];
  logic [15:0] exp_rd_a[$], exp_rd_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [7:0]  ew;
    logic [15:0] er;
    if (wd_a != '0) begin
      if (exp_wr_a.size() == 0) chk("a_write_unexpected", 32'(wd_a), 32'(0));
      else begin ew = exp_wr_a.pop_front(); chk("a_write_done", 32'(wd_a), 32'(ew)); end
    end
    if (rd_a != '0) begin
      if (exp_rd_a.size() == 0) chk("a_read_unexpected", 32'(rd_a), 32'(0));
      else begin
        er = exp_rd_a.pop_front();
        chk("a_read_port", 32'(rd_a), 32'(1) << er[15:8]);
        chk("a_read_data", 32'(out_a[er[15:8]*8 +: 8]), 32'(er[7:0]));
      end
    end
    if (wd_b != '0) begin
      if (exp_wr_b.size() == 0) chk("b_write_unexpected", 32'(wd_b), 32'(0));
      else begin ew = exp_wr_b.pop_front(); chk("b_write_done", 32'(wd_b), 32'(ew)); end
    end
    if (rd_b != '0) begin
      if (exp_rd_b.size() == 0) chk("b_read_unexpected", 32'(rd_b), 32'(0));
      else begin
        er = exp_rd_b.pop_front();
        chk("b_read_port", 32'(rd_b), 32'(1) << er[15:8]);
        chk("b_read_data", 32'(out_b[er[15:8]*8 +: 8]), 32'(er[7:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] peek_tab [4];
    peek_tab = '{8'h10, 8'h11, 8'h12, 8'h10};
    rst_a = 1'b1; rst_b = 1'b1;
    in_a = '0; we_a = '0; re_a = '0;
    in_b = '0; we_b = '0; re_b = '0;
    repeat (2) step();
    chk("rst_a_count", 32'(cnt_a), 0);
    chk("rst_a_peek", 32'(peek_a), 0);
    chk("rst_a_done", 32'({wd_a, rd_a}), 0);
    chk("rst_a_out", 32'(out_a), 0);
    chk("rst_b_count", 32'(cnt_b), 0);
    chk("rst_b_out", 32'(out_b), 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // A: single write, then a second write blocked until a read frees the cell
    we_a = 2'b01; in_a[7:0] = 8'hAA; exp_wr_a.push_back(8'h01);
    step();
    chk("t1_count_full", 32'(cnt_a), 1);
    chk("t1_peek", 32'(peek_a), 32'hAA);
    we_a = 2'b00;
    we_a = 2'b10; in_a[15:8] = 8'hBB;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_blocked_done", 32'(wd_a), 0);
      chk("t1_blocked_count", 32'(cnt_a), 1);
    end
    re_a = 2'b01; exp_rd_a.push_back({8'd0, 8'hAA});
    step();
    chk("t1_after_read_count", 32'(cnt_a), 0);
    re_a = 2'b00; exp_wr_a.push_back(8'h02);
    step();
    chk("t1_refill_count", 32'(cnt_a), 1);
    chk("t1_refill_peek", 32'(peek_a), 32'hBB);
    we_a = 2'b00;

    // A: both readers contending, refills in between; grants 0,1,0
    re_a = 2'b11; exp_rd_a.push_back({8'd0, 8'hBB});
    step();
    in_a[7:0] = 8'h01; we_a = 2'b01; exp_wr_a.push_back(8'h01);
    step();
    chk("t2_refill1_count", 32'(cnt_a), 1);
    we_a = 2'b00; exp_rd_a.push_back({8'd1, 8'h01});
    step();
    in_a[7:0] = 8'h02; we_a = 2'b01; exp_wr_a.push_back(8'h01);
    step();
    we_a = 2'b00; exp_rd_a.push_back({8'd0, 8'h02});
    step();
    re_a = 2'b00;
    chk("t2_empty_count", 32'(cnt_a), 0);

    // A: reader blocked on empty queue until a write arrives
    re_a = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_blocked_read", 32'(rd_a), 0);
    end
    we_a = 2'b10; in_a[15:8] = 8'h33; exp_wr_a.push_back(8'h02);
    step();
    we_a = 2'b00;
    chk("t5_write_count", 32'(cnt_a), 1);
    exp_rd_a.push_back({8'd0, 8'h33});
    step();
    re_a = 2'b00;
    chk("t5_read_count", 32'(cnt_a), 0);

    // B: three writers contending fill the queue in round-robin order
    in_b = {8'h12, 8'h11, 8'h10}; we_b = 3'b111;
    exp_wr_b.push_back(8'h01); exp_wr_b.push_back(8'h02);
    exp_wr_b.push_back(8'h04); exp_wr_b.push_back(8'h01);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_fill_count", 32'(cnt_b), 32'(i + 1));
      chk("t3_fill_peek", 32'(peek_b), 32'(peek_tab[i]));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t3_full_count", 32'(cnt_b), 4);
      chk("t3_full_done", 32'(wd_b), 0);
    end
    we_b = 3'b000;

    // B: drain to two, then simultaneous write+read with pointer wrap
    re_b = 2'b01; exp_rd_b.push_back({8'd0, 8'h10}); exp_rd_b.push_back({8'd0, 8'h11});
    step(); step();
    re_b = 2'b00;
    chk("t4_count2", 32'(cnt_b), 2);
    we_b = 3'b001; in_b[7:0] = 8'h55; re_b = 2'b01;
    exp_wr_b.push_back(8'h01); exp_rd_b.push_back({8'd0, 8'h12});
    step();
    chk("t4_simul1_count", 32'(cnt_b), 2);
    chk("t4_simul1_peek", 32'(peek_b), 32'h55);
    in_b[7:0] = 8'h56; exp_wr_b.push_back(8'h01); exp_rd_b.push_back({8'd0, 8'h10});
    step();
    chk("t4_simul2_count", 32'(cnt_b), 2);
    in_b[7:0] = 8'h57; exp_wr_b.push_back(8'h01); exp_rd_b.push_back({8'd0, 8'h55});
    step();
    chk("t4_simul3_count", 32'(cnt_b), 2);
    chk("t4_simul3_peek", 32'(peek_b), 32'h57);
    we_b = 3'b000;
    exp_rd_b.push_back({8'd0, 8'h56}); exp_rd_b.push_back({8'd0, 8'h57});
    step(); step();
    re_b = 2'b00;
    chk("t4_drained_count", 32'(cnt_b), 0);

    // B: reset at occupancy three with requests pending
    we_b = 3'b010; in_b[15:8] = 8'h61;
    repeat (3) exp_wr_b.push_back(8'h02);
    repeat (3) step();
    we_b = 3'b000;
    chk("t6_pre_count", 32'(cnt_b), 3);
    rst_b = 1'b1; we_b = 3'b100; in_b[23:16] = 8'h77; re_b = 2'b10;
    step();
    chk("t6_rst_count", 32'(cnt_b), 0);
    chk("t6_rst_peek", 32'(peek_b), 0);
    chk("t6_rst_done", 32'({wd_b, rd_b}), 0);
    rst_b = 1'b0; exp_wr_b.push_back(8'h04);
    step();
    chk("t6_first_write", 32'(wd_b), 32'h4);
    chk("t6_first_count", 32'(cnt_b), 1);
    chk("t6_first_peek", 32'(peek_b), 32'h77);
    we_b = 3'b000; exp_rd_b.push_back({8'd1, 8'h77});
    step();
    re_b = 2'b00;
    chk("t6_final_count", 32'(cnt_b), 0);

    repeat (2) step();
    chk("a_wr_queue_empty", 32'(exp_wr_a.size()), 0);
    chk("a_rd_queue_empty", 32'(exp_rd_a.size()), 0);
    chk("b_wr_queue_empty", 32'(exp_wr_b.size()), 0);
    chk("b_rd_queue_empty", 32'(exp_rd_b.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
